// File: rtl/dm_port_arbiter.sv
// Shares the M-stage data memory port with an external requester.
// DM_PORT_ARB_STARVE_EN enables the starvation counter.
module dm_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter logic [31:0] DM_BYTES = 32'h3000,
    parameter logic [31:0] EXT_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [2:0]  m_type,
    input  logic [31:0] m_pc,
    output logic [31:0] m_rdata,
    output logic        m_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [2:0]  ext_type,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    output logic        ext_err,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic [2:0]  dm_type,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rd
);

    logic starve;
    logic ext_own;
    logic m_own;
    logic ext_oor;

    if (MAX_WAIT == 0 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("MAX_WAIT must be in 1..15");
    end

    assign ext_oor = (ext_addr >= DM_BYTES);
    assign ext_own = ext_req & (~m_req | starve);
    assign m_own   = m_req & ~ext_own;

`ifdef DM_PORT_ARB_STARVE_EN
    logic [3:0] wait_cnt;

    assign starve = (wait_cnt == 4'(MAX_WAIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (!ext_req || ext_own) begin
            wait_cnt <= 4'd0;
        end else if (!starve) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    assign starve = 1'b0;
`endif

    assign ext_gnt = ext_own;
    assign m_stall = m_req & ext_own;
    assign m_rdata = dm_rd;

    // M stage stays on the bus when idle; only the write enable is gated
    always_comb begin
        dm_we   = 1'b0;
        dm_addr = m_addr;
        dm_wd   = m_wdata;
        dm_type = m_type;
        dm_pc   = m_pc;
        if (ext_own) begin
            dm_we   = ext_we & ~ext_oor;
            dm_addr = ext_addr;
            dm_wd   = ext_wdata;
            dm_type = ext_type;
            dm_pc   = EXT_PC;
        end else if (m_own) begin
            dm_we = m_we;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_rvalid <= 1'b0;
            ext_rdata  <= 32'd0;
            ext_err    <= 1'b0;
        end else if (ext_own) begin
            ext_rvalid <= 1'b1;
            ext_rdata  <= (ext_we || ext_oor) ? 32'd0 : dm_rd;
            ext_err    <= ext_oor;
        end else begin
            ext_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small word memory model.
// Starvation expectations follow DM_PORT_ARB_STARVE_EN.
module tb_dm_port_arbiter;

    localparam logic [31:0] PCV = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata, m_pc;
    logic [2:0]  m_type;
    logic [31:0] m_rdata;
    logic        m_stall;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr, ext_wdata;
    logic [2:0]  ext_type;
    logic        ext_gnt, ext_rvalid, ext_err;
    logic [31:0] ext_rdata;
    logic        dm_we;
    logic [31:0] dm_addr, dm_wd, dm_pc, dm_rd;
    logic [2:0]  dm_type;

    logic [31:0] mem [64] = '{default: 32'd0};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dm_we) mem[dm_addr[7:2]] <= dm_wd;
    end
    assign dm_rd = mem[dm_addr[7:2]];

    dm_port_arbiter dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_type(m_type), .m_pc(m_pc),
        .m_rdata(m_rdata), .m_stall(m_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_type(ext_type),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .ext_rdata(ext_rdata), .ext_err(ext_err),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .dm_type(dm_type), .dm_pc(dm_pc), .dm_rd(dm_rd)
    );

    typedef struct {
        string       name;
        logic        mr, mw;
        logic [31:0] ma, md;
        logic        er, ew;
        logic [31:0] ea, ed;
        logic        x_stall, x_gnt, x_we;
        logic [31:0] x_addr, x_mrd;
        logic        x_rv;
        logic [31:0] x_rd;
        logic        x_err;
    } vec_t;

    vec_t v [18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic mw,
                         input logic [31:0] ma, input logic [31:0] md,
                         input logic er, input logic ew,
                         input logic [31:0] ea, input logic [31:0] ed);
        m_req = mr; m_we = mw; m_addr = ma; m_wdata = md;
        ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
    endtask

    initial begin
        v[0]  = '{"idle",      0,0,32'h0,32'h0,         0,0,32'h0,32'h0,
                  0,0,0,32'h0,32'h0,          0,32'h0,0};
        v[1]  = '{"m_store",   1,1,32'h10,32'h12345678, 0,0,32'h0,32'h0,
                  0,0,1,32'h10,32'h0,         0,32'h0,0};
        v[2]  = '{"m_load",    1,0,32'h10,32'h0,        0,0,32'h0,32'h0,
                  0,0,0,32'h10,32'h12345678,  0,32'h0,0};
        v[3]  = '{"ext_rd",    0,0,32'h0,32'h0,         1,0,32'h10,32'h0,
                  0,1,0,32'h10,32'h12345678,  0,32'h0,0};
        v[4]  = '{"ext_rsp",   0,0,32'h0,32'h0,         0,0,32'h0,32'h0,
                  0,0,0,32'h0,32'h0,          1,32'h12345678,0};
        v[5]  = '{"ext_wr",    0,0,32'h0,32'h0,         1,1,32'h20,32'hAABBCCDD,
                  0,1,1,32'h20,32'h0,         0,32'h12345678,0};
        v[6]  = '{"b2b_rd20",  0,0,32'h0,32'h0,         1,0,32'h20,32'h0,
                  0,1,0,32'h20,32'hAABBCCDD,  1,32'h0,0};
        v[7]  = '{"b2b_rd10",  0,0,32'h0,32'h0,         1,0,32'h10,32'h0,
                  0,1,0,32'h10,32'h12345678,  1,32'hAABBCCDD,0};
        v[8]  = '{"oor_wr",    0,0,32'h0,32'h0,         1,1,32'h3000,32'hDEADBEEF,
                  0,1,0,32'h3000,32'h0,       1,32'h12345678,0};
        v[9]  = '{"rd0",       0,0,32'h0,32'h0,         1,0,32'h0,32'h0,
                  0,1,0,32'h0,32'h0,          1,32'h0,1};
        v[10] = '{"rd0_rsp",   0,0,32'h0,32'h0,         0,0,32'h0,32'h0,
                  0,0,0,32'h0,32'h0,          1,32'h0,0};
        v[11] = '{"idle2",     0,0,32'h0,32'h0,         0,0,32'h0,32'h0,
                  0,0,0,32'h0,32'h0,          0,32'h0,0};
        v[12] = '{"oor_rd",    0,0,32'h0,32'h0,         1,0,32'h3004,32'h0,
                  0,1,0,32'h3004,32'h0,       0,32'h0,0};
        v[13] = '{"oor_rsp",   0,0,32'h0,32'h0,         0,0,32'h0,32'h0,
                  0,0,0,32'h0,32'h0,          1,32'h0,1};
        v[14] = '{"err_hold",  0,0,32'h0,32'h0,         0,0,32'h0,32'h0,
                  0,0,0,32'h0,32'h0,          0,32'h0,1};
        v[15] = '{"both_m",    1,0,32'h20,32'h0,        1,0,32'h10,32'h0,
                  0,0,0,32'h20,32'hAABBCCDD,  0,32'h0,1};
        v[16] = '{"ext_after", 0,0,32'h0,32'h0,         1,0,32'h10,32'h0,
                  0,1,0,32'h10,32'h12345678,  0,32'h0,1};
        v[17] = '{"rsp_last",  0,0,32'h0,32'h0,         0,0,32'h0,32'h0,
                  0,0,0,32'h0,32'h0,          1,32'h12345678,0};

        m_pc = PCV; m_type = 3'd0; ext_type = 3'd2;
        drive(0,0,0,0,0,0,0,0);
        reset = 1'b1;
        #2;
        chk("rst_rvalid", 32'(ext_rvalid), 32'd0);
        chk("rst_rdata", ext_rdata, 32'd0);
        chk("rst_err", 32'(ext_err), 32'd0);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
`ifdef DM_PORT_ARB_STARVE_EN
        chk("rst_wait", 32'(dut.wait_cnt), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(v[i].mr, v[i].mw, v[i].ma, v[i].md,
                  v[i].er, v[i].ew, v[i].ea, v[i].ed);
            #1;
            chk({v[i].name, ".stall"}, 32'(m_stall), 32'(v[i].x_stall));
            chk({v[i].name, ".gnt"}, 32'(ext_gnt), 32'(v[i].x_gnt));
            chk({v[i].name, ".dm_we"}, 32'(dm_we), 32'(v[i].x_we));
            chk({v[i].name, ".dm_addr"}, dm_addr, v[i].x_addr);
            chk({v[i].name, ".dm_pc"}, dm_pc,
                v[i].x_gnt ? 32'h0 : PCV);
            chk({v[i].name, ".dm_type"}, 32'(dm_type),
                v[i].x_gnt ? 32'd2 : 32'd0);
            chk({v[i].name, ".m_rdata"}, m_rdata, v[i].x_mrd);
            chk({v[i].name, ".rvalid"}, 32'(ext_rvalid), 32'(v[i].x_rv));
            chk({v[i].name, ".rdata"}, ext_rdata, v[i].x_rd);
            chk({v[i].name, ".err"}, 32'(ext_err), 32'(v[i].x_err));
        end

        // continuous M stream against a held external read
        @(negedge clk);
        drive(0,0,0,0,0,0,0,0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            drive(1,0,32'h10,0, 1,0,32'h0,0);
            #1;
`ifdef DM_PORT_ARB_STARVE_EN
            chk($sformatf("starve_gnt_c%0d", c), 32'(ext_gnt),
                32'(c == 5));
            chk($sformatf("starve_stall_c%0d", c), 32'(m_stall),
                32'(c == 5));
            if (c == 6) chk("starve_wait_clr", 32'(dut.wait_cnt), 32'd0);
`else
            chk($sformatf("strict_gnt_c%0d", c), 32'(ext_gnt), 32'd0);
            chk($sformatf("strict_stall_c%0d", c), 32'(m_stall), 32'd0);
`endif
        end
        @(negedge clk);
        drive(0,0,0,0, 1,0,32'h0,0);
        #1;
        chk("mdrop_gnt", 32'(ext_gnt), 32'd1);

        // reset during an external grant drops the response
        @(negedge clk);
        drive(0,0,0,0,0,0,0,0);
        @(negedge clk);
        drive(0,0,0,0, 1,0,32'h10,0);
        #1;
        chk("rstx_gnt", 32'(ext_gnt), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rstx_rvalid0", 32'(ext_rvalid), 32'd0);
        @(negedge clk);
        drive(0,0,0,0,0,0,0,0);
        #1;
        chk("rstx_rvalid1", 32'(ext_rvalid), 32'd0);
`ifdef DM_PORT_ARB_STARVE_EN
        chk("rstx_wait", 32'(dut.wait_cnt), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        drive(1,0,32'h10,0, 0,0,0,0);
        #1;
        chk("rstx_rvalid2", 32'(ext_rvalid), 32'd0);
        chk("post_rst_stall", 32'(m_stall), 32'd0);
        chk("post_rst_load", m_rdata, 32'h12345678);
        @(negedge clk);
        drive(0,0,0,0,0,0,0,0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
